serial_frame_tx: RTL
====================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame.
REQ-002 The block SHALL have parameter BIT_TICKS, default 4, meaning Clock cycles per serial bit (legal range 1..255).
REQ-003 The block SHALL have parameter PARITY_EN, default 1, meaning 1 = even-parity bit inserted after data, 0 = no parity bit.
REQ-004 The block SHALL have port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port Load, input, 1 bit, a request to transmit Data.
REQ-007 The block SHALL have port Data, input, DATA_W bits, the payload, sampled only on an accepted Load.
REQ-008 The block SHALL have port Ready, output, 1 bit; high when a Load would be accepted.
REQ-009 The block SHALL have port Q, output, 1 bit, the registered serial line; idle level is 1.
REQ-010 The block SHALL have port Busy, output, 1 bit; high while a frame is on the line.
REQ-011 The block SHALL have port Done, output, 1 bit, a one-cycle pulse at frame end.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-013 Load SHALL be accepted only when Load=1 and Ready=1 at a rising edge; the edge SHALL latch Data into a shift register and enter START.
REQ-014 Load SHALL be ignored while Busy=1, with no queuing and no effect on the frame in flight.
REQ-015 Ready SHALL equal (state==IDLE); Busy SHALL equal !Ready.
REQ-016 Q SHALL be 0 in START, shift-register LSB in DATA, even parity (XOR of latched Data) in PARITY, and 1 in STOP and IDLE.
REQ-017 Q SHALL change on the edge that accepts Load: first start-bit cycle is the cycle after acceptance.
REQ-018 Each of START, each DATA bit, PARITY and STOP SHALL hold Q for exactly BIT_TICKS cycles, timed by a tick counter reset to 0 on every bit boundary.
REQ-019 DATA SHALL transmit LSB first; the shift register SHALL shift right one place per bit; a bit index SHALL count 0..DATA_W-1 and leave DATA after index DATA_W-1.
REQ-020 After DATA the FSM SHALL enter PARITY if PARITY_EN=1, else STOP.
REQ-021 Frame length SHALL be (2+DATA_W+PARITY_EN)*BIT_TICKS cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
REQ-022 Done SHALL be 1 during the last STOP cycle only; Ready SHALL be 1 in the following cycle.
REQ-023 A Load held high continuously SHALL be accepted again in the first Ready cycle, giving back-to-back frames with no idle gap beyond that single cycle.
REQ-024 Changes on Data while Busy SHALL NOT affect the transmitted frame.
REQ-025 With BIT_TICKS=1, every bit SHALL last exactly one cycle.

Reset
REQ-026 Reset=1 at a rising edge SHALL force state IDLE, Q=1, Ready=1, Busy=0, Done=0, and clear the counters and shift register, taking priority over Load.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no Done pulse; Q SHALL be 1 in the cycle after the reset edge.

Structure
REQ-028 FSM state encodings, the idle line level and the parity-mode constants SHALL live in the shared package/include serial_pkg.
REQ-029 Bit timing SHALL be implemented in one sub-module, bit_timer, with inputs Clock, Reset and clear, and output tick_last, which is high on the BIT_TICKS-th cycle.

Verification
REQ-030 Reset during idle: Q=1, Ready=1, Busy=0, Done=0 after the reset edge.
REQ-031 Load with Data=8'hA5, BIT_TICKS=4, PARITY_EN=1 -> Q bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total, and one Done pulse in cycle 44.
REQ-032 Load 8'h01 with PARITY_EN=0 -> sequence 0,1,0,0,0,0,0,0,0,1 (40 cycles); Load pulsed again at cycle 10 is ignored.
REQ-033 Load held high with Data 8'hFF, then 8'h00 -> two frames; parity bits 0 and 0; exactly one Ready cycle between the frames.
REQ-034 Reset asserted in cycle 20 of an 8'h3C frame -> Q=1 and Ready=1 at the next cycle, no Done pulse, and a new Load of 8'h3C transmits correctly.
REQ-035 BIT_TICKS=1 with Data 8'h80 -> 11-cycle frame 0,0,0,0,0,0,0,0,1,1,1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Line levels, FSM encoding and parity modes live here.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit tick counter: tick_last marks the final cycle of a bit.
// clear restarts the count at every bit boundary.
module bit_timer #(
  parameter int BIT_TICKS = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  output logic tick_last
);

  localparam logic [7:0] LAST = 8'(BIT_TICKS - 1);

  logic [7:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick_last = (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, LSB-first data, optional even
// parity and stop bit, each held BIT_TICKS cycles on a registered line.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BIT_TICKS = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic [DATA_W-1:0] Data,
  output logic              Ready,
  output logic              Q,
  output logic              Busy,
  output logic              Done
);

  localparam int IDX_W = idx_width(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              par, par_n;
  logic              q_n;
  logic              tick_last;
  logic              clear;

  assign Ready = (state == ST_IDLE);
  assign Busy  = !Ready;
  assign Done  = (state == ST_STOP) && tick_last;
  assign clear = Ready || tick_last;

  bit_timer #(
    .BIT_TICKS(BIT_TICKS)
  ) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (clear),
    .tick_last(tick_last)
  );

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    idx_n   = idx;
    par_n   = par;
    unique case (state)
      ST_IDLE: begin
        if (Load) begin
          state_n = ST_START;
          sreg_n  = Data;
          par_n   = ^Data;
          idx_n   = '0;
        end
      end
      ST_START: begin
        if (tick_last) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (tick_last) begin
          sreg_n = sreg >> 1;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = (PARITY_EN == PARITY_EVEN)
                    ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick_last) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (tick_last) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line is registered from the next state so it moves with the FSM.
  always_comb begin
    q_n = IDLE_LEVEL;
    unique case (1'b1)
      (state_n == ST_START):  q_n = START_LEVEL;
      (state_n == ST_DATA):   q_n = sreg_n[0];
      (state_n == ST_PARITY): q_n = par_n;
      (state_n == ST_STOP):   q_n = STOP_LEVEL;
      default:                q_n = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      sreg  <= '0;
      idx   <= '0;
      par   <= 1'b0;
      Q     <= IDLE_LEVEL;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      idx   <= idx_n;
      par   <= par_n;
      Q     <= q_n;
    end
  end

endmodule
